// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, parity and stop bits.
// Each bit is decided by a 3-sample majority vote, and the receiver recovers from errors on its own.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic                 rx_busy,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int M  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic                 sync1, sync2, sync_prev;
    logic [1:0]           samp;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 perr_acc, ferr_acc;
    logic                 fall, maj, decide, last;

    assign fall    = sync_prev & ~sync2;
    assign maj     = (samp[0] & samp[1]) | (samp[0] & sync2) | (samp[1] & sync2);
    assign decide  = (cnt == CNT_DEC);
    assign last    = (cnt == CNT_LAST);
    assign rx_busy = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE || last)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // The final stop bit ends at its decision point so the next start edge is caught promptly.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (fall) state_next = START;
            START: begin
                if (decide && maj)
                    state_next = IDLE;
                else if (last)
                    state_next = DATA;
            end
            DATA: begin
                if (last && bit_idx == BIT_LAST)
                    state_next = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: if (last) state_next = STOP;
            STOP:   if (decide && stop_idx == STOP_LAST) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp     <= 2'b11;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (cnt == CNT_S0) samp[0] <= sync2;
            if (cnt == CNT_S1) samp[1] <= sync2;

            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && last)
                bit_idx <= bit_idx + 1'b1;

            if (state != STOP)
                stop_idx <= 1'b0;
            else if (last)
                stop_idx <= stop_idx + 1'b1;

            if (state == DATA && decide)
                shift <= {maj, shift[DATA_BITS-1:1]};

            if (state == IDLE && fall) begin
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end else begin
                if (state == PARITY && decide)
                    perr_acc <= ((^shift) ^ maj) != (PARITY_MODE == 2);
                if (state == STOP && decide && !maj)
                    ferr_acc <= 1'b1;
            end
        end
    end

    // Results are loaded on the transition into DONE so they change together with rx_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= (state_next == DONE);
            if (state_next == DONE) begin
                rx_data    <= shift;
                parity_err <= perr_acc;
                frame_err  <= ferr_acc | ~maj;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) driven from a frame-level model.
module tb_uart_rx_param;

    localparam int NCH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rx_line = 3'b111;

    logic busy0, busy1, busy2, val0, val1, val2;
    logic pe0, pe1, pe2, fe0, fe1, fe2;
    logic [7:0] data0, data1;
    logic [6:0] data2;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [2:0] prev_valid = 3'b000;

    typedef struct {
        int ch;
        int data;
        bit perr;
        bit ferr;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx_in(rx_line[0]), .rx_busy(busy0), .rx_valid(val0),
        .rx_data(data0), .parity_err(pe0), .frame_err(fe0));

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx_in(rx_line[1]), .rx_busy(busy1), .rx_valid(val1),
        .rx_data(data1), .parity_err(pe1), .frame_err(fe1));

    uart_rx_param #(.CLKS_PER_BIT(13), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .rx_in(rx_line[2]), .rx_busy(busy2), .rx_valid(val2),
        .rx_data(data2), .parity_err(pe2), .frame_err(fe2));

    function automatic int cpb_of(input int ch);   return (ch == 2) ? 13 : 16; endfunction
    function automatic int dbits_of(input int ch); return (ch == 2) ? 7 : 8;   endfunction
    function automatic int pmode_of(input int ch); return ch;                  endfunction
    function automatic int sbits_of(input int ch); return (ch == 2) ? 2 : 1;   endfunction

    function automatic logic get_valid(input int ch);
        case (ch) 0: return val0; 1: return val1; default: return val2; endcase
    endfunction
    function automatic logic get_busy(input int ch);
        case (ch) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_perr(input int ch);
        case (ch) 0: return pe0; 1: return pe1; default: return pe2; endcase
    endfunction
    function automatic logic get_ferr(input int ch);
        case (ch) 0: return fe0; 1: return fe1; default: return fe2; endcase
    endfunction
    function automatic logic [31:0] get_data(input int ch);
        case (ch)
            0: return {24'h0, data0};
            1: return {24'h0, data1};
            default: return {25'h0, data2};
        endcase
    endfunction

    task automatic checkOutput(input string name, input int ch, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s ch%0d: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, ch, actual, expected, cyc);
        end
    endtask

    // Sends one frame on channel ch; stop_low is a mask of stop bits driven low,
    // glitch_bit (>=0) inverts one cycle near the middle of that data bit.
    task automatic applyStimulus(input int ch, input int data, input bit par_flip,
                                 input int stop_low, input int glitch_bit, input int gap);
        int c, m, d, p, s, n;
        bit bits[$];
        bit par_ok;
        exp_t e;
        c = cpb_of(ch);
        m = c / 2;
        d = dbits_of(ch);
        p = pmode_of(ch);
        s = sbits_of(ch);
        data = data & ((1 << d) - 1);
        bits.push_back(1'b0);
        for (int i = 0; i < d; i++) bits.push_back(data[i]);
        par_ok = 1'b0;
        if (p != 0) begin
            par_ok = (($countones(data) % 2) == 1) ^ (p == 2);
            bits.push_back(par_ok ^ par_flip);
        end
        for (int k = 0; k < s; k++) bits.push_back(~stop_low[k]);
        n = bits.size() - 1;
        e.ch   = ch;
        e.data = data;
        e.perr = (p != 0) && par_flip;
        e.ferr = (stop_low & ((1 << s) - 1)) != 0;
        e.cyc  = cyc + n * c + m + 5;
        exp_q.push_back(e);
        foreach (bits[j]) begin
            for (int i = 0; i < c; i++) begin
                rx_line[ch] = (j == glitch_bit + 1 && i == m + 1) ? ~bits[j] : bits[j];
                @(negedge clk);
            end
        end
        if (gap > 0) begin
            rx_line[ch] = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (get_valid(ch) === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_valid ch%0d: got data 0x%0h at cycle %0d, expected no frame",
                             ch, get_data(ch), cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("channel", ch, ch, e.ch);
                    checkOutput("rx_data", ch, get_data(ch), e.data);
                    checkOutput("parity_err", ch, get_perr(ch), e.perr);
                    checkOutput("frame_err", ch, get_ferr(ch), e.ferr);
                    checkOutput("valid_cycle", ch, cyc, e.cyc);
                    checkOutput("busy_in_done", ch, get_busy(ch), 0);
                end
                checkOutput("valid_width", ch, prev_valid[ch], 0);
            end
        end
        prev_valid <= {val2, val1, val0};
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int pd;
        int waitc;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            checkOutput("reset_busy", ch, get_busy(ch), 0);
            checkOutput("reset_valid", ch, get_valid(ch), 0);
            checkOutput("reset_data", ch, get_data(ch), 0);
            checkOutput("reset_perr", ch, get_perr(ch), 0);
            checkOutput("reset_ferr", ch, get_ferr(ch), 0);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(0, 'hA5, 1'b0, 0, -1, 4);
        applyStimulus(1, 'h3C, 1'b1, 0, -1, 2);
        applyStimulus(1, 'h3C, 1'b0, 0, -1, 2);

        // Framing error, then a long low hold that must not start a frame.
        applyStimulus(0, 'h55, 1'b0, 1, -1, 0);
        rx_line[0] = 1'b0;
        repeat (40) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(0, 'h12, 1'b0, 0, -1, 3);

        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        checkOutput("false_start_busy", 0, busy0, 1);
        repeat (12) @(negedge clk);
        checkOutput("false_start_idle", 0, busy0, 0);
        applyStimulus(0, 'hF0, 1'b0, 0, 2, 3);

        applyStimulus(2, 'h41, 1'b0, 0, -1, 0);
        applyStimulus(2, 'h7F, 1'b0, 0, -1, 3);

        // Reset in the middle of data bit 4.
        pd = 'hC3;
        rx_line[1] = 1'b0;
        repeat (16) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            rx_line[1] = pd[b];
            repeat (16) @(negedge clk);
        end
        rx_line[1] = pd[4];
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_busy", 1, busy1, 0);
        checkOutput("midreset_valid", 1, val1, 0);
        checkOutput("midreset_data", 1, {24'h0, data1}, 0);
        checkOutput("midreset_perr", 1, pe1, 0);
        checkOutput("midreset_ferr", 1, fe1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rx_line[1] = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(1, 'h99, 1'b0, 0, -1, 3);

        for (int it = 0; it < 24; it++) begin
            int ch, d, sl, gl, gap;
            bit flip;
            ch   = $urandom_range(0, 2);
            d    = $urandom;
            flip = ($urandom_range(0, 3) == 0);
            sl   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            gl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, dbits_of(ch) - 1) : -1;
            gap  = $urandom_range(0, 3);
            if (((sl >> (sbits_of(ch) - 1)) & 1) != 0 && gap == 0) gap = 1;
            applyStimulus(ch, d, flip, sl, gl, gap);
        end
        rx_line = 3'b111;

        waitc = 0;
        while (exp_q.size() != 0 && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("queue_drained", 0, exp_q.size(), 0);
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver. It replaces the fixed 8N1 receiver in the serial path and supports:
- configurable data width, parity mode and stop-bit count;
- 3-sample majority voting per bit;
- false-start rejection;
- per-frame parity and framing error flags with automatic recovery, so there is no lock-up error state.

It sits between the asynchronous serial input pin and the byte-consumer logic. Each received word is delivered as a single-cycle `rx_valid` pulse.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit period; legal range ≥ 8.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line, idle high, LSB first; asynchronous to clk.
- rx_busy  out  1  high while a frame is in progress (START..STOP).
- rx_valid  out  1  one-cycle pulse: `rx_data` and the error flags are valid.
- rx_data  out  DATA_BITS  last received word; held until the next `rx_valid`.
- parity_err  out  1  parity mismatch of the current frame; meaningful only with `rx_valid`.
- frame_err  out  1  a stop bit sampled low; meaningful only with `rx_valid`.

## Operation
- **Input conditioning.** `rx_in` passes through a 2-flop synchronizer, reset value 1. A falling-edge detector (previous sync = 1, current sync = 0) starts frames. A line held low, such as a break, never retriggers.
- **Bit timer.** `cnt` counts 0..CLKS_PER_BIT-1, restarts at 0 on every state change, and wraps at CLKS_PER_BIT-1.
  - Let M = CLKS_PER_BIT/2 (integer division).
  - Samples are taken at cnt = M-1, M and M+1.
  - The bit value is the majority of the three samples and is available at cnt = M+1.
- **State machine (IDLE, START, DATA, PARITY, STOP, DONE):**
  - IDLE: falling edge → START.
  - START:
    - Majority = 1 at cnt = M+1 → IDLE (false start, no `rx_valid`).
    - Otherwise cnt = CLKS_PER_BIT-1 → DATA.
  - DATA: the decided bit shifts into the shift register MSB-ward, so bit 0 is received first and ends at `rx_data[0]`. After DATA_BITS bit periods → PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: the decided bit is compared against the XOR of the data bits. Even mode: XOR of data bits ^ parity bit must be 0. Odd mode: it must be 1. One period → STOP.
  - STOP:
    - Any stop bit decided 0 sets `frame_err`.
    - Non-final stop bits last a full period.
    - On the final stop bit, go to DONE at cnt = M+1 (half-period early, so back-to-back frames resync on the next start edge).
  - DONE: one cycle → IDLE.
- **Outputs in DONE.** In DONE, `rx_valid` = 1, `rx_data` loads the shift register, and `parity_err`/`frame_err` carry the frame result. The data word is delivered even when an error flag is set.
- **Flags.** `parity_err` and `frame_err` clear on entry to START. `parity_err` stays 0 when PARITY_MODE = 0.
- **Error recovery.** No error state persists. After `frame_err`, a new frame requires the line to return high and fall again.
- **Reset values:** state IDLE, cnt 0, sync flops 1, `rx_busy` 0, `rx_valid` 0, `rx_data` 0, `parity_err` 0, `frame_err` 0.
- **Reset mid-frame** aborts the frame immediately: no `rx_valid` and no partial data in `rx_data`.

## Timing
- START is entered 1 cycle after the synchronized falling edge, which is 3 cycles after `rx_in` falls.
- Let N = DATA_BITS + (PARITY_MODE ≠ 0) + STOP_BITS. `rx_valid` asserts N·CLKS_PER_BIT + M + 2 cycles after START entry.
- `rx_busy` is 1 from START entry through the last STOP cycle; it is 0 in DONE and IDLE.
- `rx_valid` is exactly 1 cycle wide.
- `rx_data` and the flags change only in the same cycle that `rx_valid` rises.
- Minimum idle gap between frames: 0. A start edge is accepted in the first IDLE cycle after DONE.
- A low glitch shorter than M-1 cycles is rejected as a false start. The receiver returns to IDLE at START cnt = M+1.

## Test plan
- **8N1 baseline.** CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=0, send 0xA5 → one `rx_valid` pulse, `rx_data`=0xA5, both flags 0, timing per the formula above.
- **Even parity error.** PARITY_MODE=1, send 0x3C with parity bit 1 → `rx_data`=0x3C, `parity_err`=1, `frame_err`=0. Then a correct frame 0x3C with parity bit 0 → `parity_err`=0.
- **Framing error and recovery.** Send 0x55 with the stop bit low, then hold the line low 40 cycles, release, and send 0x12 → first frame `frame_err`=1, `rx_data`=0x55. No spurious frame during the low hold. Second frame 0x12 with no errors.
- **False start and noise.** A 3-cycle low pulse → no `rx_valid`, `rx_busy` returns to 0. A frame 0xF0 with a 1-cycle inverted glitch at the mid-sample of bit 2 → `rx_data`=0xF0 (majority vote).
- **Back-to-back frames.** DATA_BITS=7, STOP_BITS=2, PARITY_MODE=2, zero idle gap, send 0x41 then 0x7F → two `rx_valid` pulses, correct data, flags 0.
- **Reset mid-frame.** Assert `rst` during DATA bit 4 of a frame → all outputs at reset values immediately. After release, the next full frame 0x99 is received correctly.
